pps_timekeeper: RTL and testbench
=================================

Name: pps_timekeeper

Overview:
- Consumes the single-cycle PPS edge pulse produced by the Pos_Edge stage. Keeps a clk-cycle sub-second counter and a binary HH:MM:SS time of day, both disciplined to GPS PPS.
- Three modes: free-runs when no PPS has been seen, tracks PPS within a tolerance window, and flywheels through missing pulses (holdover). Feeds the display/formatting stage downstream.

Parameters:
- CLK_HZ, 50000000, clk cycles per nominal second; sub-second counter wraps at CLK_HZ-1.
- PPS_TOL, 1000, half-width of the acceptance window in cycles; legal range 1 <= PPS_TOL < CLK_HZ/2.
- HOLD_MAX, 16, number of consecutive missed PPS tolerated in HOLDOVER before falling back to UNLOCKED; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pps_pe  in  1  one-cycle PPS rising-edge pulse from the edge detector.
- tod_load  in  1  one-cycle load strobe for the time of day.
- tod_hh  in  5  load hours, 0-23.
- tod_mm  in  6  load minutes, 0-59.
- tod_ss  in  6  load seconds, 0-59.
- sec_tick  out  1  one-cycle pulse at every second boundary.
- sub_sec  out  $clog2(CLK_HZ)  sub-second cycle count.
- hh  out  5  hours.
- mm  out  6  minutes.
- ss  out  6  seconds.
- locked  out  1  high while in LOCKED.
- holdover  out  1  high while in HOLDOVER.
- pps_err  out  1  one-cycle pulse when a PPS is rejected.

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is asynchronous, active-low (rst_n).
  - Every output resets to 0; the state machine resets to UNLOCKED.
  - Reset asserted mid-operation discards all state immediately.
- Sub-second counter and tick:
  - sub_sec increments by 1 each cycle and wraps CLK_HZ-1 -> 0. Each wrap asserts sec_tick in the cycle sub_sec is 0.
- Acceptance window (W): sub_sec in [CLK_HZ-PPS_TOL, CLK_HZ-1] (early half) or [0, PPS_TOL-1] (late half).
- Per-window flag seen:
  - Set when a PPS is accepted.
  - Evaluated and cleared in the cycle sub_sec == PPS_TOL.
- Realignment, applied when a PPS is accepted in LOCKED or HOLDOVER:
  - Early half: next sub_sec = 0 and sec_tick is asserted that cycle; this replaces the wrap tick.
  - Late half: next sub_sec = 0 with no extra tick, since that second was already ticked.
  - A pps_pe on the exact wrap cycle (sub_sec == CLK_HZ-1) gives exactly one tick.
- States:
  - UNLOCKED: free-run. Any pps_pe forces sub_sec to 0, asserts sec_tick, and moves to LOCKED (hard align).
  - LOCKED:
    - pps_pe in W with seen == 0: accept and realign.
    - pps_pe outside W, or with seen == 1: ignore and pulse pps_err.
    - At sub_sec == PPS_TOL with seen == 0: go to HOLDOVER with miss_cnt = 1.
  - HOLDOVER:
    - Free-run on local wraps.
    - Accepted PPS: realign, go to LOCKED, clear miss_cnt.
    - Rejected PPS: pps_err, as in LOCKED.
    - Each window close with seen == 0 increments miss_cnt. When miss_cnt reaches HOLD_MAX, go to UNLOCKED.
- Time of day:
  - On each sec_tick: ss increments; 59 -> 0 carries to mm; mm 59 -> 0 carries to hh; hh 23 -> 0.
  - tod_load applies the load values on the next cycle.
  - If tod_load coincides with sec_tick, the load wins (no increment); sec_tick is still emitted.
  - A load with any field out of range is ignored entirely and pulses pps_err is NOT used; it is silently dropped.
- Latency: sec_tick, hh/mm/ss, locked and holdover are all registered outputs. sec_tick appears the cycle after a pps_pe is sampled.

Optional Feature:
- Macro: PPS_TIMEKEEPER_STATS_EN.
- When defined, adds the output pps_offset (signed, $clog2(CLK_HZ)+1 bits).
  - Holds the phase of the last accepted PPS: early-half offset = sub_sec - CLK_HZ (negative); late-half offset = sub_sec (positive).
  - Also adds the output miss_total (16 bits, saturating) counting window closes with seen == 0.
  - Both outputs reset to 0.
- When not defined, neither port exists and no counters are built.

Test Plan (CLK_HZ=100, PPS_TOL=5, HOLD_MAX=3):
1. Reset release, no PPS -> sec_tick every 100 cycles, ss counts 0,1,2; locked=0, holdover=0.
2. Hard align: pps_pe at an arbitrary phase in UNLOCKED -> sec_tick next cycle, sub_sec=0, locked=1. Then pps_pe every 100 cycles -> one tick per pulse, no pps_err.
3. Jitter tracking: pps_pe at 97 cycles (early) then 103 cycles (late) -> one tick each, realigned, no double tick, locked held. With STATS_EN: pps_offset = -3 then +3.
4. Rejections: pps_pe at sub_sec=50 -> pps_err=1, no tick, state unchanged. A second pps_pe in the same window -> pps_err=1.
5. Holdover: stop PPS while LOCKED -> holdover=1 at sub_sec=5. Free-run continues, and after 3 missed windows -> UNLOCKED. Separately, a PPS resumed within the window during HOLDOVER -> back to LOCKED.
6. Time of day:
   - Load 23:59:58, then two ticks -> 23:59:59 then 00:00:00.
   - tod_load coincident with sec_tick -> loaded value held.
   - Load with tod_mm=60 -> ignored.

Source files
------------

// File: rtl/pps_timekeeper.sv
`timescale 1ns/1ps
// pps_timekeeper: PPS-disciplined sub-second counter and binary HH:MM:SS time of day.
// Optional build macro PPS_TIMEKEEPER_STATS_EN adds the pps_offset and miss_total outputs.
//
// state      | meaning
// UNLOCKED   | free-run with no PPS reference; the next PPS hard-aligns the counter
// LOCKED     | tracking PPS inside the acceptance window
// HOLDOVER   | PPS missing; flywheel on local wraps and count missed windows
module pps_timekeeper #(
  parameter int CLK_HZ   = 50000000,
  parameter int PPS_TOL  = 1000,
  parameter int HOLD_MAX = 16,
  localparam int SW      = $clog2(CLK_HZ)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pps_pe,
  input  logic          tod_load,
  input  logic [4:0]    tod_hh,
  input  logic [5:0]    tod_mm,
  input  logic [5:0]    tod_ss,
  output logic          sec_tick,
  output logic [SW-1:0] sub_sec,
  output logic [4:0]    hh,
  output logic [5:0]    mm,
  output logic [5:0]    ss,
  output logic          locked,
  output logic          holdover,
  output logic          pps_err
`ifdef PPS_TIMEKEEPER_STATS_EN
  ,
  output logic signed [SW:0] pps_offset,
  output logic [15:0]        miss_total
`endif
);

  // miss_cnt never needs to hold HOLD_MAX itself: reaching it drops straight to UNLOCKED
  localparam int MW = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);

  localparam logic [SW-1:0] SUB_LAST  = SW'(CLK_HZ - 1);
  localparam logic [SW-1:0] WIN_LO    = SW'(CLK_HZ - PPS_TOL);
  localparam logic [SW-1:0] TOL_AT    = SW'(PPS_TOL);
  localparam logic [MW-1:0] HOLD_LAST = MW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {S_UNLOCKED, S_LOCKED, S_HOLDOVER} state_t;

  state_t        state;
  logic          seen;
  logic [MW-1:0] miss_cnt;

  logic wrap, early, in_win, win_close;
  logic hard, accept, reject, tick_nxt, load_ok;

  // Window classification and PPS accept/reject decisions for the current sub_sec
  always_comb begin
    wrap      = (sub_sec == SUB_LAST);
    early     = (sub_sec >= WIN_LO);
    in_win    = early || (sub_sec < TOL_AT);
    win_close = (sub_sec == TOL_AT);
    hard      = pps_pe && (state == S_UNLOCKED);
    accept    = pps_pe && (state != S_UNLOCKED) && in_win && !seen;
    reject    = pps_pe && (state != S_UNLOCKED) && !(in_win && !seen);
    // an early-half realign supplies the tick that the wrap would have given
    tick_nxt  = hard || (accept ? early : wrap);
    load_ok   = tod_load && (tod_hh < 5'd24) && (tod_mm < 6'd60) && (tod_ss < 6'd60);
  end

  // Sub-second counter with realignment to zero on a hard align or accepted PPS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_sec  <= '0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= tick_nxt;
      if (hard || accept || wrap) sub_sec <= '0;
      else                        sub_sec <= sub_sec + SW'(1);
    end
  end

  // Lock state machine; locked/holdover are registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_UNLOCKED;
      seen     <= 1'b0;
      miss_cnt <= '0;
      locked   <= 1'b0;
      holdover <= 1'b0;
      pps_err  <= 1'b0;
    end else begin
      pps_err <= reject;
      case (state)
        S_UNLOCKED: begin
          if (hard) begin
            state  <= S_LOCKED;
            locked <= 1'b1;
            seen   <= 1'b1;
          end else if (win_close) begin
            seen <= 1'b0;
          end
        end
        S_LOCKED: begin
          if (accept) begin
            seen <= 1'b1;
          end else if (win_close) begin
            seen <= 1'b0;
            if (!seen) begin
              locked <= 1'b0;
              if (HOLD_MAX == 1) begin
                state <= S_UNLOCKED;
              end else begin
                state    <= S_HOLDOVER;
                holdover <= 1'b1;
                miss_cnt <= MW'(1);
              end
            end
          end
        end
        S_HOLDOVER: begin
          if (accept) begin
            state    <= S_LOCKED;
            locked   <= 1'b1;
            holdover <= 1'b0;
            seen     <= 1'b1;
            miss_cnt <= '0;
          end else if (win_close) begin
            seen <= 1'b0;
            if (!seen) begin
              if (miss_cnt == HOLD_LAST) begin
                state    <= S_UNLOCKED;
                holdover <= 1'b0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + MW'(1);
              end
            end
          end
        end
        default: begin
          state    <= S_UNLOCKED;
          locked   <= 1'b0;
          holdover <= 1'b0;
          seen     <= 1'b0;
          miss_cnt <= '0;
        end
      endcase
    end
  end

  // Time of day: a valid load beats a same-cycle increment; invalid loads are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hh <= '0;
      mm <= '0;
      ss <= '0;
    end else if (load_ok) begin
      hh <= tod_hh;
      mm <= tod_mm;
      ss <= tod_ss;
    end else if (tick_nxt) begin
      if (ss == 6'd59) begin
        ss <= '0;
        if (mm == 6'd59) begin
          mm <= '0;
          hh <= (hh == 5'd23) ? 5'd0 : hh + 5'd1;
        end else begin
          mm <= mm + 6'd1;
        end
      end else begin
        ss <= ss + 6'd1;
      end
    end
  end

`ifdef PPS_TIMEKEEPER_STATS_EN
  // Phase of the last accepted PPS and saturating count of empty window closes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pps_offset <= '0;
      miss_total <= '0;
    end else begin
      if (accept) begin
        if (early) pps_offset <= $signed({1'b0, sub_sec}) - $signed((SW+1)'(CLK_HZ));
        else       pps_offset <= $signed({1'b0, sub_sec});
      end
      if (win_close && !seen && (state != S_UNLOCKED) && (miss_total != 16'hFFFF))
        miss_total <= miss_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pps_timekeeper.sv
`timescale 1ns/1ps
// Bench for pps_timekeeper at CLK_HZ=100, PPS_TOL=5, HOLD_MAX=3.
module tb_pps_timekeeper;

  localparam int HZ  = 100;
  localparam int TOL = 5;
  localparam int HM  = 3;
  localparam int SW  = $clog2(HZ);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pps_pe = 1'b0;
  logic          tod_load = 1'b0;
  logic [4:0]    tod_hh = '0;
  logic [5:0]    tod_mm = '0;
  logic [5:0]    tod_ss = '0;
  logic          sec_tick;
  logic [SW-1:0] sub_sec;
  logic [4:0]    hh;
  logic [5:0]    mm;
  logic [5:0]    ss;
  logic          locked;
  logic          holdover;
  logic          pps_err;

  pps_timekeeper #(.CLK_HZ(HZ), .PPS_TOL(TOL), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .pps_pe(pps_pe), .tod_load(tod_load),
    .tod_hh(tod_hh), .tod_mm(tod_mm), .tod_ss(tod_ss),
    .sec_tick(sec_tick), .sub_sec(sub_sec), .hh(hh), .mm(mm), .ss(ss),
    .locked(locked), .holdover(holdover), .pps_err(pps_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int tick_cnt = 0;
  int err_cnt = 0;

  // Reference model: mode 0 free-run, 1 locked, 2 holdover; time of day in seconds
  int m_sub, m_mode, m_seen, m_miss, m_tod, m_tick, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sub = 0; m_mode = 0; m_seen = 0; m_miss = 0; m_tod = 0; m_tick = 0; m_err = 0;
  endtask

  task automatic model_edge();
    int s0, mode0, seen0, nsub;
    bit inwin, early;
    s0 = m_sub; mode0 = m_mode; seen0 = m_seen;
    early = (s0 >= HZ - TOL);
    inwin = early || (s0 < TOL);
    nsub = (s0 + 1) % HZ;
    m_tick = (nsub == 0);
    m_err = 0;
    if (s0 == TOL) begin
      if (mode0 != 0 && seen0 == 0) begin
        if (mode0 == 1) begin
          m_miss = 1;
          m_mode = (HM == 1) ? 0 : 2;
          if (HM == 1) m_miss = 0;
        end else begin
          m_miss++;
          if (m_miss == HM) begin m_mode = 0; m_miss = 0; end
        end
      end
      m_seen = 0;
    end
    if (pps_pe) begin
      if (mode0 == 0) begin
        nsub = 0; m_tick = 1; m_mode = 1; m_seen = 1;
      end else if (inwin && seen0 == 0) begin
        nsub = 0; m_tick = early; m_mode = 1; m_seen = 1; m_miss = 0;
      end else begin
        m_err = 1;
      end
    end
    m_sub = nsub;
    if (tod_load && tod_hh < 24 && tod_mm < 60 && tod_ss < 60)
      m_tod = tod_hh * 3600 + tod_mm * 60 + tod_ss;
    else if (m_tick != 0)
      m_tod = (m_tod + 1) % 86400;
  endtask

  // One clock: advance the model at the edge, compare all outputs 1 ns later, clear strobes
  task automatic step();
    bit ok;
    @(posedge clk);
    model_edge();
    #1;
    ok = (sub_sec === SW'(m_sub)) && (sec_tick === 1'(m_tick)) &&
         (hh === 5'(m_tod / 3600)) && (mm === 6'((m_tod / 60) % 60)) && (ss === 6'(m_tod % 60)) &&
         (locked === (m_mode == 1)) && (holdover === (m_mode == 2)) && (pps_err === 1'(m_err));
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL cycle t=%0t got sub=%0d tick=%0b tod=%0d:%0d:%0d lk=%0b ho=%0b err=%0b expected sub=%0d tick=%0d tod=%0d:%0d:%0d lk=%0d ho=%0d err=%0d",
               $time, sub_sec, sec_tick, hh, mm, ss, locked, holdover, pps_err,
               m_sub, m_tick, m_tod / 3600, (m_tod / 60) % 60, m_tod % 60, m_mode == 1, m_mode == 2, m_err);
    end
    if (sec_tick === 1'b1) tick_cnt++;
    if (pps_err === 1'b1) err_cnt++;
    pps_pe = 1'b0;
    tod_load = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_sub", 32'(sub_sec), 0);
    check("rst_tick_lock_hold_err", {sec_tick, locked, holdover, pps_err}, 0);
    check("rst_tod", {hh, mm, ss}, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_sub(input int target, input int limit, input string name);
    int n = 0;
    while (sub_sec != SW'(target) && n < limit) begin step(); n++; end
    check(name, 32'(sub_sec), target);
  endtask

  task automatic wait_tick(input int limit, input string name);
    int n = 0;
    do begin step(); n++; end while (sec_tick !== 1'b1 && n < limit);
    check(name, 32'(sec_tick), 1);
  endtask

  task automatic wait_holdover(input logic want, input int limit, output int n);
    n = 0;
    do begin step(); n++; end while (holdover !== want && n < limit);
  endtask

  task automatic load(input int h, input int m, input int s);
    tod_hh = 5'(h); tod_mm = 6'(m); tod_ss = 6'(s); tod_load = 1'b1;
  endtask

  typedef struct {
    int lh, lm, ls;
    int eh, em, es;
  } tod_vec_t;

  tod_vec_t tv[8];

  initial begin
    int t0, e0, n;
    tv[0] = '{23, 59, 58, 23, 59, 58};
    tv[1] = '{24,  0,  0, 23, 59, 58};
    tv[2] = '{ 0, 60,  0, 23, 59, 58};
    tv[3] = '{ 0,  0, 60, 23, 59, 58};
    tv[4] = '{ 7,  8,  9,  7,  8,  9};
    tv[5] = '{31, 63, 63,  7,  8,  9};
    tv[6] = '{ 0,  0,  0,  0,  0,  0};
    tv[7] = '{23, 59, 58, 23, 59, 58};

    model_reset();
    do_reset();

    // free-run from reset: a tick every 100 cycles
    t0 = tick_cnt;
    repeat (300) step();
    check("free_ticks", 32'(tick_cnt - t0), 3);
    check("free_ss", 32'(ss), 3);
    check("free_lock_hold", {locked, holdover}, 0);

    // time-of-day load vectors, including out-of-range fields
    for (int i = 0; i < 8; i++) begin
      load(tv[i].lh, tv[i].lm, tv[i].ls);
      step();
      check($sformatf("tod_vec%0d", i), {hh, mm, ss},
            {5'(tv[i].eh), 6'(tv[i].em), 6'(tv[i].es)});
    end

    // day rollover
    wait_tick(200, "roll_tick1");
    check("roll_1", {hh, mm, ss}, {5'd23, 6'd59, 6'd59});
    wait_tick(200, "roll_tick2");
    check("roll_2", {hh, mm, ss}, {5'd0, 6'd0, 6'd0});

    // load coincident with a tick: load wins, tick still emitted
    run_until_sub(HZ - 1, 200, "reach_wrap");
    load(10, 20, 30);
    step();
    check("coinc_tick", 32'(sec_tick), 1);
    check("coinc_tod", {hh, mm, ss}, {5'd10, 6'd20, 6'd30});
    load(11, 60, 0);
    step();
    check("bad_mm_tod", {hh, mm, ss}, {5'd10, 6'd20, 6'd30});

    // hard align at arbitrary phase
    repeat ($urandom_range(10, 60)) step();
    pps_pe = 1'b1;
    step();
    check("align_tick", 32'(sec_tick), 1);
    check("align_sub", 32'(sub_sec), 0);
    check("align_locked", 32'(locked), 1);
    for (int k = 0; k < 3; k++) begin
      t0 = tick_cnt; e0 = err_cnt;
      repeat (HZ - 1) step();
      pps_pe = 1'b1;
      step();
      check("track_ticks", 32'(tick_cnt - t0), 1);
      check("track_errs", 32'(err_cnt - e0), 0);
    end

    // jitter: early by 3 then late by 3
    t0 = tick_cnt; e0 = err_cnt;
    repeat (97) step();
    pps_pe = 1'b1;
    step();
    check("early_tick", 32'(sec_tick), 1);
    check("early_sub", 32'(sub_sec), 0);
    repeat (103) step();
    pps_pe = 1'b1;
    step();
    check("late_tick", 32'(sec_tick), 0);
    check("late_sub", 32'(sub_sec), 0);
    check("jitter_ticks", 32'(tick_cnt - t0), 2);
    check("jitter_errs", 32'(err_cnt - e0), 0);
    check("jitter_locked", 32'(locked), 1);

    // rejections: out of window, then a second PPS in one window
    repeat (50) step();
    pps_pe = 1'b1;
    step();
    check("rej_err", 32'(pps_err), 1);
    check("rej_tick", 32'(sec_tick), 0);
    check("rej_sub", 32'(sub_sec), 51);
    check("rej_locked", 32'(locked), 1);
    repeat (48) step();
    pps_pe = 1'b1;
    step();
    check("acc_tick", 32'(sec_tick), 1);
    step();
    pps_pe = 1'b1;
    step();
    check("dup_err", 32'(pps_err), 1);
    check("dup_tick", 32'(sec_tick), 0);

    // holdover after PPS stops, then fall back to free-run after three misses
    wait_holdover(1'b1, 300, n);
    check("hold_enter", {locked, holdover}, 2'b01);
    check("hold_enter_cycles", 32'(n), 104);
    wait_holdover(1'b0, 400, n);
    check("hold_exit", {locked, holdover}, 2'b00);
    check("hold_exit_cycles", 32'(n), 2 * HZ);

    // holdover recovery with an in-window PPS
    pps_pe = 1'b1;
    step();
    check("realign_locked", 32'(locked), 1);
    wait_holdover(1'b1, 300, n);
    check("hold2_enter", {locked, holdover}, 2'b01);
    run_until_sub(97, 200, "reach_97");
    pps_pe = 1'b1;
    step();
    check("recover", {locked, holdover, sec_tick}, 3'b101);

    // randomized phases of PPS density and loads, checked by the model every cycle
    for (int seg = 0; seg < 8; seg++) begin
      int p_in, p_out;
      case (seg % 4)
        0: begin p_in = 20; p_out = 0; end
        1: begin p_in = 0;  p_out = 0; end
        2: begin p_in = 5;  p_out = 2; end
        default: begin p_in = 60; p_out = 1; end
      endcase
      for (int c = 0; c < 500; c++) begin
        bit inw;
        inw = (m_sub >= HZ - TOL) || (m_sub < TOL);
        pps_pe = ($urandom_range(0, 99) < (inw ? p_in : p_out));
        if ($urandom_range(0, 99) == 0)
          load($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
        step();
      end
      if (seg == 4) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
